// File: rtl/pc_ras_if.sv
// Fetch-control bundle between the PC/return-address-stack unit and its driver.
// Exception signals exist only when PC_EXC_EN is defined.
interface pc_ras_if #(
  parameter int unsigned PC_W      = 16,
  parameter int unsigned RAS_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

  logic             hlt;
  logic             stall;
  logic [1:0]       pc_src;
  logic [PC_W-1:0]  target;
  logic [PC_W-1:0]  pc;
  logic             halted;
  logic [PC_W-1:0]  ras_top;
  logic [CNT_W-1:0] ras_count;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_ovf;
  logic             ras_unf;
`ifdef PC_EXC_EN
  logic             exc;
  logic             eret;
  logic [PC_W-1:0]  epc;
  logic             in_exc;
`endif

  modport master (
`ifdef PC_EXC_EN
    output exc, eret,
    input  epc, in_exc,
`endif
    output hlt, stall, pc_src, target,
    input  pc, halted, ras_top, ras_count, ras_empty, ras_full, ras_ovf, ras_unf
  );

  modport slave (
`ifdef PC_EXC_EN
    input  exc, eret,
    output epc, in_exc,
`endif
    input  hlt, stall, pc_src, target,
    output pc, halted, ras_top, ras_count, ras_empty, ras_full, ras_ovf, ras_unf
  );
endinterface

// File: rtl/pc_ras_unit.sv
// Program counter with circular return-address stack, stall and sticky halt.
// Optional exception entry/return (epc, in_exc) is built when PC_EXC_EN is defined.
module pc_ras_unit #(
  parameter int unsigned       PC_W      = 16,
  parameter int unsigned       RAS_DEPTH = 4,
  parameter logic [PC_W-1:0]   RESET_VEC = '0,
  parameter logic [PC_W-1:0]   INC       = PC_W'(1)
`ifdef PC_EXC_EN
  , parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(16'h0100)
`endif
) (
  input  logic    clk,
  input  logic    rst_n,
  pc_ras_if.slave bus
);
  localparam int unsigned SP_W  = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = SP_W + 1;

  typedef enum logic [1:0] {
    SRC_SEQ  = 2'b00,
    SRC_JMP  = 2'b01,
    SRC_CALL = 2'b10,
    SRC_RET  = 2'b11
  } pc_src_e;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic             halted_q, halted_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  ras_q [RAS_DEPTH];
`ifdef PC_EXC_EN
  logic [PC_W-1:0]  epc_q, epc_d;
  logic             in_exc_q, in_exc_d;
`endif

  logic             push, pop;
  logic             empty, full;
  logic [PC_W-1:0]  pc_inc, top;
  pc_src_e          src;

  assign src    = pc_src_e'(bus.pc_src);
  assign pc_inc = pc_q + INC;
  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CNT_W'(RAS_DEPTH));
  // sp_q points at the next free slot; power-of-2 depth makes the decrement wrap.
  assign top    = empty ? RESET_VEC : ras_q[sp_q - SP_W'(1)];

  always_comb begin
    // NOTE: every target gets a hold default first, so no path infers a latch.
    pc_d     = pc_q;
    halted_d = halted_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    pop      = 1'b0;
`ifdef PC_EXC_EN
    epc_d    = epc_q;
    in_exc_d = in_exc_q;
`endif
    if (halted_q || bus.hlt) begin
      halted_d = 1'b1;
    end
`ifdef PC_EXC_EN
    else if (bus.exc) begin
      pc_d = EXC_VEC;
      if (!in_exc_q) begin
        epc_d    = pc_q;
        in_exc_d = 1'b1;
      end
    end else if (bus.eret) begin
      pc_d     = epc_q;
      in_exc_d = 1'b0;
    end
`endif
    else if (!bus.stall) begin
      unique case (src)
        SRC_SEQ: pc_d = pc_inc;
        SRC_JMP: pc_d = bus.target;
        SRC_CALL: begin
          pc_d = bus.target;
          push = 1'b1;
          // A full stack overwrites its oldest entry, which sits at sp_q.
          if (full) ovf_d = 1'b1;
          else      cnt_d = cnt_q + CNT_W'(1);
        end
        SRC_RET: begin
          if (empty) begin
            pc_d  = pc_inc;
            unf_d = 1'b1;
          end else begin
            pc_d  = top;
            pop   = 1'b1;
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: pc_d = pc_q;
      endcase
    end
  end

  always_comb begin
    sp_d = sp_q;
    if (push)     sp_d = sp_q + SP_W'(1);
    else if (pop) sp_d = sp_q - SP_W'(1);
  end

  // NOTE: state uses nonblocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_VEC;
      halted_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      sp_q     <= '0;
      cnt_q    <= '0;
`ifdef PC_EXC_EN
      epc_q    <= '0;
      in_exc_q <= 1'b0;
`endif
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      sp_q     <= sp_d;
      cnt_q    <= cnt_d;
`ifdef PC_EXC_EN
      epc_q    <= epc_d;
      in_exc_q <= in_exc_d;
`endif
    end
  end

  // NOTE: stack storage is not reset; cnt_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) ras_q[sp_q] <= pc_inc;
  end

  assign bus.pc        = pc_q;
  assign bus.halted    = halted_q;
  assign bus.ras_top   = top;
  assign bus.ras_count = cnt_q;
  assign bus.ras_empty = empty;
  assign bus.ras_full  = full;
  assign bus.ras_ovf   = ovf_q;
  assign bus.ras_unf   = unf_q;
`ifdef PC_EXC_EN
  assign bus.epc       = epc_q;
  assign bus.in_exc    = in_exc_q;
`endif
endmodule

// File: tb/tb_pc_ras_unit.sv
// Self-checking bench for pc_ras_unit: directed plan plus randomized traffic
// compared each cycle against a queue-based reference model.
module tb_pc_ras_unit;
  localparam int unsigned PC_W  = 16;
  localparam int unsigned DEPTH = 4;
  localparam logic [15:0] RVEC  = 16'h0000;
  localparam logic [15:0] EVEC  = 16'h0100;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pc_ras_if #(.PC_W(PC_W), .RAS_DEPTH(DEPTH)) bus ();

  pc_ras_unit #(.PC_W(PC_W), .RAS_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the stack is a queue, newest at the back.
  logic [15:0] m_pc;
  logic        m_halted, m_ovf, m_unf;
  logic [15:0] m_stack [$];
  logic [15:0] m_epc;
  logic        m_in_exc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RVEC; m_halted = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    m_stack.delete();
    m_epc = '0; m_in_exc = 1'b0;
  endtask

  task automatic model_step(input logic h, input logic s, input logic [1:0] src,
                            input logic [15:0] tgt, input logic e, input logic er);
    if (m_halted || h) begin
      m_halted = 1'b1;
    end
`ifdef PC_EXC_EN
    else if (e) begin
      if (!m_in_exc) begin m_epc = m_pc; m_in_exc = 1'b1; end
      m_pc = EVEC;
    end else if (er) begin
      m_pc = m_epc; m_in_exc = 1'b0;
    end
`endif
    else if (!s) begin
      case (src)
        2'd0: m_pc = m_pc + 16'd1;
        2'd1: m_pc = tgt;
        2'd2: begin
          m_stack.push_back(m_pc + 16'd1);
          if (m_stack.size() > DEPTH) begin
            void'(m_stack.pop_front());
            m_ovf = 1'b1;
          end
          m_pc = tgt;
        end
        default: begin
          if (m_stack.size() == 0) begin
            m_pc = m_pc + 16'd1; m_unf = 1'b1;
          end else begin
            m_pc = m_stack.pop_back();
          end
        end
      endcase
    end
  endtask

  task automatic compare_all(input string tag);
    logic [15:0] exp_top;
    exp_top = (m_stack.size() == 0) ? RVEC : m_stack[$];
    check({tag, ".pc"},     32'(bus.pc),        32'(m_pc));
    check({tag, ".halted"}, 32'(bus.halted),    32'(m_halted));
    check({tag, ".top"},    32'(bus.ras_top),   32'(exp_top));
    check({tag, ".count"},  32'(bus.ras_count), 32'(m_stack.size()));
    check({tag, ".empty"},  32'(bus.ras_empty), 32'(m_stack.size() == 0));
    check({tag, ".full"},   32'(bus.ras_full),  32'(m_stack.size() == DEPTH));
    check({tag, ".ovf"},    32'(bus.ras_ovf),   32'(m_ovf));
    check({tag, ".unf"},    32'(bus.ras_unf),   32'(m_unf));
`ifdef PC_EXC_EN
    check({tag, ".epc"},    32'(bus.epc),       32'(m_epc));
    check({tag, ".in_exc"}, 32'(bus.in_exc),    32'(m_in_exc));
`endif
  endtask

  // Reset is asserted and checked between edges, so its asynchronous effect is visible.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    model_reset();
    compare_all(tag);
    rst_n = 1'b1;
  endtask

  task automatic step(input string tag, input logic h, input logic s, input logic [1:0] src,
                      input logic [15:0] tgt, input logic e = 1'b0, input logic er = 1'b0);
    bus.hlt = h; bus.stall = s; bus.pc_src = src; bus.target = tgt;
`ifdef PC_EXC_EN
    bus.exc = e; bus.eret = er;
`endif
    @(posedge clk);
    model_step(h, s, src, tgt, e, er);
    #1;
    compare_all(tag);
  endtask

  initial begin
    logic        rh, rs, re, rer;
    logic [1:0]  rsrc;
    logic [15:0] rtgt;

    bus.hlt = 1'b0; bus.stall = 1'b0; bus.pc_src = 2'b00; bus.target = '0;
`ifdef PC_EXC_EN
    bus.exc = 1'b0; bus.eret = 1'b0;
`endif
    #1;
    do_reset("reset");
    check("reset.pc_const", 32'(bus.pc), 32'h0);
    check("reset.empty_const", 32'(bus.ras_empty), 32'h1);

    for (int i = 0; i < 5; i++) step("seq", 1'b0, 1'b0, 2'b00, 16'h0);
    check("seq5.pc", 32'(bus.pc), 32'h5);

    step("jmp", 1'b0, 1'b0, 2'b01, 16'hFFFF);
    check("jmp.pc", 32'(bus.pc), 32'hFFFF);
    step("wrap", 1'b0, 1'b0, 2'b00, 16'h0);
    check("wrap.pc", 32'(bus.pc), 32'h0);

    // Call at pc=3, run two sequential steps, return to 4.
    do_reset("rst_call");
    for (int i = 0; i < 3; i++) step("seq", 1'b0, 1'b0, 2'b00, 16'h0);
    step("call", 1'b0, 1'b0, 2'b10, 16'h0040);
    check("call.pc", 32'(bus.pc), 32'h40);
    check("call.count", 32'(bus.ras_count), 32'h1);
    step("seq", 1'b0, 1'b0, 2'b00, 16'h0);
    step("seq", 1'b0, 1'b0, 2'b00, 16'h0);
    check("body.pc", 32'(bus.pc), 32'h42);
    step("ret", 1'b0, 1'b0, 2'b11, 16'h0);
    check("ret.pc", 32'(bus.pc), 32'h4);
    check("ret.count", 32'(bus.ras_count), 32'h0);

    // Five calls overflow a 4-deep stack; the first return address (1) is lost.
    do_reset("rst_ovf");
    for (int i = 0; i < 5; i++) step("call5", 1'b0, 1'b0, 2'b10, 16'(16'h0100 * (i + 1)));
    check("ovf.full", 32'(bus.ras_full), 32'h1);
    check("ovf.flag", 32'(bus.ras_ovf), 32'h1);
    check("ovf.count", 32'(bus.ras_count), 32'h4);
    for (int i = 4; i >= 1; i--) begin
      step("ret4", 1'b0, 1'b0, 2'b11, 16'h0);
      check("ret4.pc", 32'(bus.pc), 32'(16'h0100 * i + 1));
    end
    step("ret_unf", 1'b0, 1'b0, 2'b11, 16'h0);
    check("unf.flag", 32'(bus.ras_unf), 32'h1);
    check("unf.pc", 32'(bus.pc), 32'h0102);

    // Stall holds a call; halt freezes everything until an asynchronous reset.
    do_reset("rst_halt");
    step("jmp7", 1'b0, 1'b0, 2'b01, 16'h0007);
    step("stall_call", 1'b0, 1'b1, 2'b10, 16'h0055);
    check("stall.pc", 32'(bus.pc), 32'h7);
    check("stall.count", 32'(bus.ras_count), 32'h0);
    step("hlt", 1'b1, 1'b0, 2'b00, 16'h0);
    check("hlt.halted", 32'(bus.halted), 32'h1);
    for (int i = 0; i < 6; i++)
      step("halted", 1'b0, 1'(i % 2), 2'(i), 16'h1234);
    check("halted.pc", 32'(bus.pc), 32'h7);
    #2;
    do_reset("rst_mid_halt");
    check("rst_halt.pc", 32'(bus.pc), 32'h0);
    check("rst_halt.halted", 32'(bus.halted), 32'h0);

`ifdef PC_EXC_EN
    step("jmp20", 1'b0, 1'b0, 2'b01, 16'h0020);
    step("exc1", 1'b0, 1'b0, 2'b00, 16'h0, 1'b1, 1'b0);
    check("exc1.pc", 32'(bus.pc), 32'h100);
    check("exc1.epc", 32'(bus.epc), 32'h20);
    step("exc2", 1'b0, 1'b0, 2'b00, 16'h0, 1'b1, 1'b1);
    check("exc2.epc", 32'(bus.epc), 32'h20);
    step("eret", 1'b0, 1'b0, 2'b00, 16'h0, 1'b0, 1'b1);
    check("eret.pc", 32'(bus.pc), 32'h20);
    check("eret.in_exc", 32'(bus.in_exc), 32'h0);
`endif

    // Randomized traffic with occasional halts and periodic resets.
    do_reset("rst_rand");
    for (int i = 0; i < 3000; i++) begin
      if (i % 400 == 399) do_reset("rst_rand");
      rh   = ($urandom_range(0, 299) == 0);
      rs   = ($urandom_range(0, 4) == 0);
      rsrc = 2'($urandom_range(0, 3));
      rtgt = 16'($urandom);
      re   = ($urandom_range(0, 19) == 0);
      rer  = ($urandom_range(0, 19) == 0);
      step("rand", rh, rs, rsrc, rtgt, re, rer);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
Parametrised program-counter unit for the next-generation WISC fetch stage. Supports sequential, jump/branch, call and return sources. Holds a circular return-address stack (RAS) for calls and returns, with stall and sticky halt control. Sits at the head of fetch and drives the instruction-memory address.

Parameters:
PC_W, 16, PC and target width in bits (>=4)
RAS_DEPTH, 4, RAS entries; power of 2, >=2
RESET_VEC, 0, PC value loaded on reset
INC, 1, sequential increment (PC_W-bit, modular)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active-low
hlt  input  1  halt request; latched sticky until reset
stall  input  1  hold PC and RAS this cycle
pc_src  input  2  00 seq, 01 jump/branch, 10 call, 11 return
target  input  PC_W  redirect target for 01/10
pc  output  PC_W  current PC (register)
halted  output  1  sticky halt flag (register)
ras_top  output  PC_W  top-of-stack entry (combinational); RESET_VEC when empty
ras_count  output  $clog2(RAS_DEPTH)+1  valid entries, 0..RAS_DEPTH
ras_empty  output  1  ras_count==0
ras_full  output  1  ras_count==RAS_DEPTH
ras_ovf  output  1  sticky: a call pushed while full
ras_unf  output  1  sticky: a return issued while empty

Behaviour:
- Reset (async, rst_n low): pc=RESET_VEC; halted=0; ras_count=0; stack pointer=0; ras_ovf=0; ras_unf=0. Entries need not be cleared. A reset mid-call or mid-return discards the operation.
- Control priority per posedge: halted|hlt, then stall, then pc_src.
- hlt=1: halted<=1 at the same edge. pc and RAS hold from that edge onward, and every later input is ignored until reset.
- stall=1 (not halted): pc, RAS and flags hold; pc_src ignored.
- pc_src=00: pc<=pc+INC, wrapping modulo 2^PC_W.
- pc_src=01: pc<=target.
- pc_src=10 (call): pc<=target; push (pc+INC) mod 2^PC_W.
  - Not full: ras_count+1.
  - Full: overwrite the oldest entry circularly; ras_count stays RAS_DEPTH; ras_ovf<=1.
- pc_src=11 (return), not empty: pc<=ras_top; pop; ras_count-1.
- pc_src=11, empty: pc<=pc+INC; ras_unf<=1; RAS unchanged.
- Latency: every redirect takes effect on pc at the next edge. No bubbles are inserted internally.
- Stack pointer wraps modulo RAS_DEPTH. Push then pop returns the most recent push. After overflow, the RAS_DEPTH newest entries are retained.
- ras_top, ras_empty and ras_full reflect registered state only, not the inputs of the current cycle.

Optional Feature:
Macro PC_EXC_EN.
- Defined: adds parameter EXC_VEC (default 16'h0100, sized to PC_W), inputs exc (1b) and eret (1b), and outputs epc (PC_W) and in_exc (1b), all reset to 0.
- Priority for exc/eret: after hlt, before stall.
- exc=1 with in_exc=0: epc<=pc; pc<=EXC_VEC; in_exc<=1; RAS untouched.
- exc=1 with in_exc=1: pc<=EXC_VEC; epc unchanged.
- eret=1 (exc=0): pc<=epc; in_exc<=0.
- exc and eret asserted together: exc wins.
- Not defined: these ports, parameter and logic are absent; behaviour is exactly as above.

Test Plan:
- Reset then 5 cycles pc_src=00 -> pc 0,1,2,3,4,5; flags 0; ras_empty=1.
- Set pc to 16'hFFFF via a 01 jump, then 00 -> pc=16'h0000 (wrap).
- At pc=3, call target 16'h0040, then 00 twice, then return -> pc 0x40,0x41,0x42,4; ras_count 1 then 0.
- 5 calls with RAS_DEPTH=4 -> ras_full=1, ras_ovf=1. Then 4 returns yield the 4 newest return addresses (LIFO order); a 5th return -> ras_unf=1, pc+1.
- stall=1 with pc_src=10 at pc=7 -> pc stays 7, ras_count unchanged. Then hlt=1 -> halted=1; pc frozen despite stall/pc_src toggling; rst_n low mid-halt -> pc=0, halted=0.
- (PC_EXC_EN) At pc=0x20, exc -> pc=0x100, epc=0x20. Second exc -> epc still 0x20. eret -> pc=0x20, in_exc=0.
